// File: rtl/alu_sequencer.sv
// alu_sequencer: three-state issue/write-back controller driving an external four-function ALU
// from an internal register file, with valid/ready handshakes on instruction and result.
module alu_sequencer #(
    parameter int WIDTH = 20,
    parameter int REGS  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_instr_valid,
    output logic                     o_instr_ready,
    input  logic [19:0]              i_instr,
    output logic [WIDTH-1:0]         o_alu_in0,
    output logic [WIDTH-1:0]         o_alu_in1,
    output logic [1:0]               o_alu_select,
    input  logic [WIDTH-1:0]         i_alu_out,
    output logic                     o_result_valid,
    input  logic                     i_result_ready,
    output logic [WIDTH-1:0]         o_result,
    input  logic                     i_wr_en,
    input  logic [$clog2(REGS)-1:0]  i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(REGS)-1:0]  i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);
    localparam int AW = $clog2(REGS);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rf [REGS];
    logic [AW-1:0]    r_dst;
    logic [WIDTH-1:0] r_in0, r_in1, r_result;
    logic [1:0]       r_sel;
    logic             r_result_valid;

    logic [1:0]       w_op;
    logic [AW-1:0]    w_dst, w_src1, w_src2;
    logic             w_imm_sel;
    logic [WIDTH-1:0] w_imm;
    logic             w_accept;

    assign w_op      = i_instr[19:18];
    assign w_dst     = i_instr[17:15];
    assign w_src1    = i_instr[14:12];
    assign w_src2    = i_instr[11:9];
    assign w_imm_sel = i_instr[8];
    assign w_imm     = {{(WIDTH-8){1'b0}}, i_instr[7:0]};
    assign w_accept  = i_instr_valid && (r_state == S_IDLE);

    assign o_instr_ready  = (r_state == S_IDLE);
    assign o_alu_in0      = r_in0;
    assign o_alu_in1      = r_in1;
    assign o_alu_select   = r_sel;
    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_rd_data      = r_rf[i_rd_addr];

    // Operands are sampled from r_rf before any same-edge preload lands (non-blocking).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_dst          <= '0;
            r_in0          <= '0;
            r_in1          <= '0;
            r_sel          <= 2'b00;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            for (int i = 0; i < REGS; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_wr_en) r_rf[i_wr_addr] <= i_wr_data;
                    if (w_accept) begin
                        r_dst   <= w_dst;
                        r_in0   <= r_rf[w_src1];
                        r_in1   <= w_imm_sel ? w_imm : r_rf[w_src2];
                        r_sel   <= w_op;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rf[r_dst]    <= i_alu_out;
                    r_result       <= i_alu_out;
                    r_result_valid <= 1'b1;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    if (i_result_ready) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
